// File: rtl/rcc_digit_buffer.sv
// rcc_digit_buffer: queues RCC characters in a FIFO with sequence check, burst-end marker and irq
module rcc_digit_buffer #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          digit_clk,
   input  logic [7:0]    din,
   input  logic          din_flag,
   input  logic          rd_en,
   input  logic [AW:0]   irq_thresh,
   input  logic          clear,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          seq_err,
   output logic          irq
);
   logic          dclk_d, last_flag, armed;
   logic [15:0]   idle_cnt;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [7:0]    mem [DEPTH];
   logic          cap, mark, push, pop, do_push, drop, ovf_next, irq_next;
   logic [7:0]    push_data;
   logic [AW:0]   count_next;

   assign empty = count == '0;
   assign full  = count == (AW+1)'(DEPTH);

   always_comb begin
      cap        = digit_clk & ~dclk_d;
      mark       = armed & ~cap & (idle_cnt == 16'(TIMEOUT - 1));
      push       = cap | mark;
      push_data  = cap ? {1'b0, din[6:0]} : 8'h80;
      pop        = rd_en & ~empty;
      do_push    = push & (~full | pop);
      drop       = push & full & ~pop;
      count_next = clear ? '0 : count + (AW+1)'(do_push) - (AW+1)'(pop);
      ovf_next   = ~clear & (overflow | drop);
      irq_next   = ovf_next | ((irq_thresh != '0) & (count_next >= irq_thresh));
   end

   always_ff @(posedge clk)
      if (!reset && !clear && do_push) mem[wr_ptr] <= push_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         dclk_d    <= 1'b0;
         last_flag <= 1'b1;
         armed     <= 1'b0;
         idle_cnt  <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         overflow  <= 1'b0;
         seq_err   <= 1'b0;
         irq       <= 1'b0;
      end else begin
         dclk_d   <= digit_clk;
         count    <= count_next;
         overflow <= ovf_next;
         irq      <= irq_next;
         if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq_err  <= 1'b0;
            armed    <= 1'b0;
            idle_cnt <= '0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= pop;
            if (pop) begin
               rd_data <= mem[rd_ptr];
               rd_ptr  <= rd_ptr + 1'b1;
            end
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (cap) begin
               seq_err   <= seq_err | (din_flag == last_flag);
               last_flag <= din_flag;
               armed     <= 1'b1;
               idle_cnt  <= '0;
            end else if (mark) begin
               armed    <= 1'b0;
               idle_cnt <= '0;
            end else if (armed) begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_rcc_digit_buffer.sv
// tb_rcc_digit_buffer: directed self-checking bench for rcc_digit_buffer
module tb_rcc_digit_buffer;
   logic       clk = 0, reset = 1, digit_clk = 0, din_flag = 0, rd_en = 0, clear = 0;
   logic [7:0] din = 0;
   logic [4:0] irq_thresh = 0;
   logic [7:0] rd_data;
   logic       rd_valid, empty, full, overflow, seq_err, irq;
   logic [4:0] count;
   int         total = 0, bad = 0;

   rcc_digit_buffer #(.DEPTH(16), .AW(4), .TIMEOUT(100)) dut (
      .clk(clk), .reset(reset), .digit_clk(digit_clk), .din(din), .din_flag(din_flag),
      .rd_en(rd_en), .irq_thresh(irq_thresh), .clear(clear), .rd_data(rd_data),
      .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
      .overflow(overflow), .seq_err(seq_err), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1; digit_clk = 0; rd_en = 0; clear = 0; irq_thresh = 0;
      tick(2);
      reset = 0;
   endtask

   task automatic push(input logic [7:0] d, input logic f);
      din = d; din_flag = f; digit_clk = 1;
      tick();
      digit_clk = 0;
      tick();
   endtask

   task automatic test_reset();
      reset = 1;
      tick(2);
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
      total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
      total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
      total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
      total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL reset_seq_err got=%b exp=0", seq_err); end
      total++; if (rd_valid !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL reset_valid_ovf got=%b%b exp=00", rd_valid, overflow); end
      reset = 0;
   endtask

   task automatic test_single();
      do_reset();
      din = 8'h35; din_flag = 0; digit_clk = 1;
      tick();
      digit_clk = 0;
      total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
      rd_en = 1;
      tick();
      rd_en = 0;
      total++; if (rd_valid !== 1'b1 || rd_data !== 8'h35) begin bad++; $display("FAIL single_pop got=%b/%h exp=1/35", rd_valid, rd_data); end
      total++; if (count !== 5'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", count); end
      tick();
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL single_valid_once got=%b exp=0", rd_valid); end
      total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL single_seq_err got=%b exp=0", seq_err); end
      rd_en = 1;
      tick();
      rd_en = 0;
      total++; if (rd_valid !== 1'b0 || rd_data !== 8'h35 || count !== 5'd0) begin bad++; $display("FAIL empty_pop got=%b/%h/%0d exp=0/35/0", rd_valid, rd_data, count); end
   endtask

   task automatic test_held();
      do_reset();
      din = 8'h31; din_flag = 0; digit_clk = 1;
      tick(3);
      digit_clk = 0;
      total++; if (count !== 5'd1) begin bad++; $display("FAIL held_count got=%0d exp=1", count); end
      tick();
      total++; if (seq_err !== 1'b0) begin bad++; $display("FAIL held_seq_err got=%b exp=0", seq_err); end
      din = 8'h32; din_flag = 0; digit_clk = 1;
      tick();
      digit_clk = 0;
      total++; if (seq_err !== 1'b1) begin bad++; $display("FAIL flag_seq_err got=%b exp=1", seq_err); end
      total++; if (count !== 5'd2) begin bad++; $display("FAIL flag_count got=%0d exp=2", count); end
      rd_en = 1;
      tick();
      total++; if (rd_data !== 8'h31) begin bad++; $display("FAIL held_pop1 got=%h exp=31", rd_data); end
      tick();
      rd_en = 0;
      total++; if (rd_data !== 8'h32 || rd_valid !== 1'b1) begin bad++; $display("FAIL held_pop2 got=%h/%b exp=32/1", rd_data, rd_valid); end
   endtask

   task automatic test_overflow();
      do_reset();
      irq_thresh = 5'd8;
      for (int i = 0; i < 16; i++) begin
         push(8'h40 + 8'(i), i[0]);
         total++; if (irq !== (i >= 7)) begin bad++; $display("FAIL ovf_irq_%0d got=%b exp=%b", i, irq, i >= 7); end
         total++; if (full !== (i == 15)) begin bad++; $display("FAIL ovf_full_%0d got=%b exp=%b", i, full, i == 15); end
      end
      push(8'h7f, 1'b0);
      total++; if (overflow !== 1'b1 || count !== 5'd16) begin bad++; $display("FAIL ovf_17th got=%b/%0d exp=1/16", overflow, count); end
      rd_en = 1;
      for (int i = 0; i < 16; i++) begin
         tick();
         total++; if (rd_data !== 8'h40 + 8'(i)) begin bad++; $display("FAIL ovf_pop_%0d got=%h exp=%h", i, rd_data, 8'h40 + 8'(i)); end
      end
      rd_en = 0;
      total++; if (empty !== 1'b1 || overflow !== 1'b1 || irq !== 1'b1) begin bad++; $display("FAIL ovf_drained got=%b%b%b exp=111", empty, overflow, irq); end
      push(8'h41, 1'b1);
      push(8'h42, 1'b0);
      clear = 1;
      tick();
      clear = 0;
      total++; if (count !== 5'd0 || empty !== 1'b1) begin bad++; $display("FAIL clear_count got=%0d/%b exp=0/1", count, empty); end
      total++; if (overflow !== 1'b0 || irq !== 1'b0) begin bad++; $display("FAIL clear_flags got=%b/%b exp=0/0", overflow, irq); end
   endtask

   task automatic test_marker();
      do_reset();
      din = 8'h39; din_flag = 0; digit_clk = 1;
      tick();
      digit_clk = 0;
      tick(98);
      total++; if (count !== 5'd1) begin bad++; $display("FAIL marker_e98 got=%0d exp=1", count); end
      tick();
      total++; if (count !== 5'd1) begin bad++; $display("FAIL marker_e99 got=%0d exp=1", count); end
      tick();
      total++; if (count !== 5'd2) begin bad++; $display("FAIL marker_e100 got=%0d exp=2", count); end
      tick(500);
      total++; if (count !== 5'd2) begin bad++; $display("FAIL marker_once got=%0d exp=2", count); end
      rd_en = 1;
      tick();
      total++; if (rd_data !== 8'h39) begin bad++; $display("FAIL marker_pop1 got=%h exp=39", rd_data); end
      tick();
      rd_en = 0;
      total++; if (rd_data !== 8'h80) begin bad++; $display("FAIL marker_pop2 got=%h exp=80", rd_data); end
      din = 8'h37; din_flag = 1; digit_clk = 1;
      tick();
      digit_clk = 0;
      tick(99);
      din = 8'h36; din_flag = 0; digit_clk = 1;
      tick();
      digit_clk = 0;
      total++; if (count !== 5'd2) begin bad++; $display("FAIL marker_pri got=%0d exp=2", count); end
      rd_en = 1;
      tick();
      total++; if (rd_data !== 8'h37) begin bad++; $display("FAIL marker_pri_pop1 got=%h exp=37", rd_data); end
      tick();
      rd_en = 0;
      total++; if (rd_data !== 8'h36 || seq_err !== 1'b0) begin bad++; $display("FAIL marker_pri_pop2 got=%h/%b exp=36/0", rd_data, seq_err); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 16; i++) push(8'h50 + 8'(i), i[0]);
      total++; if (full !== 1'b1) begin bad++; $display("FAIL b2b_full got=%b exp=1", full); end
      din = 8'hc1; din_flag = 0; digit_clk = 1; rd_en = 1;
      tick();
      digit_clk = 0;
      total++; if (count !== 5'd16 || overflow !== 1'b0) begin bad++; $display("FAIL b2b_count got=%0d/%b exp=16/0", count, overflow); end
      total++; if (rd_data !== 8'h50 || rd_valid !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h/%b exp=50/1", rd_data, rd_valid); end
      for (int i = 1; i < 17; i++) begin
         tick();
         total++; if (rd_data !== (i == 16 ? 8'h41 : 8'h50 + 8'(i))) begin bad++; $display("FAIL b2b_pop_%0d got=%h exp=%h", i, rd_data, i == 16 ? 8'h41 : 8'h50 + 8'(i)); end
      end
      rd_en = 0;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", empty); end
   endtask

   initial begin
      tick();
      test_reset();
      test_single();
      test_held();
      test_overflow();
      test_marker();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
